// File: rtl/qdr_port_arbiter.sv
// qdr_port_arbiter: round-robin share of one QDR SRAM user port.
// Optional read-return watchdog enabled by QDR_ARB_RSP_TIMEOUT_EN.
module qdr_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 36,
  parameter int BE_W      = 4,
  parameter int TAG_DEPTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_reset_z,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  input  logic [NUM_REQ*BE_W-1:0]   i_req_be,
  output logic [NUM_REQ-1:0]        o_req_grant,
  output logic                      o_mem_valid,
  output logic                      o_mem_write,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic [BE_W-1:0]           o_mem_be,
  input  logic                      i_mem_ready,
  input  logic                      i_mem_rvalid,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy,
  output logic                      o_err_unexp
`ifdef QDR_ARB_RSP_TIMEOUT_EN
  ,
  output logic                      o_err_timeout
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TAG_DEPTH < 2 ||
      (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_chk
    $error("qdr_port_arbiter: illegal parameters");
  end

  typedef enum logic {S_EMPTY, S_FULL} cmd_state_e;

  cmd_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ID_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_unexp_q, err_unexp_d;

  logic                load_ok;
  logic                tags_full;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_any;
  logic [ID_W-1:0]     gnt_id;
  logic                tag_push;
  logic                tag_pop;

  // Search starts one past the last winner, so the winner drops to last.
  always_comb begin : arb
    int k;
    k         = 0;
    load_ok   = (state_q == S_EMPTY) || i_mem_ready;
    tags_full = (cnt_q == CNT_W'(TAG_DEPTH));
    elig      = i_req_valid &
                (i_req_write | {NUM_REQ{!tags_full}});
    gnt       = '0;
    gnt_any   = 1'b0;
    gnt_id    = rr_ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (load_ok && !gnt_any && elig[k]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(k);
        gnt[k]  = 1'b1;
      end
    end
  end

  always_comb begin : cmd_reg
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (gnt_any) begin
      state_d     = S_FULL;
      rr_ptr_d    = gnt_id;
      mem_write_d = i_req_write[gnt_id];
      mem_addr_d  = i_req_addr[gnt_id*ADDR_W +: ADDR_W];
      mem_wdata_d = i_req_wdata[gnt_id*DATA_W +: DATA_W];
      mem_be_d    = i_req_be[gnt_id*BE_W +: BE_W];
    end else if (i_mem_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Reads are tagged at grant time, so queued commands count as in flight.
  always_comb begin : tag_fifo
    tag_push    = gnt_any && !i_req_write[gnt_id];
    tag_pop     = i_mem_rvalid && (cnt_q != '0);
    wr_ptr_d    = wr_ptr_q + PTR_W'(tag_push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(tag_pop);
    cnt_d       = cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_unexp_d = err_unexp_q;
    if (tag_pop) begin
      rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
      rsp_data_d = i_mem_rdata;
    end
    if (i_mem_rvalid && (cnt_q == '0)) begin
      err_unexp_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tag_push) begin
      tag_mem_q[wr_ptr_q] <= gnt_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_z) begin
    if (!i_reset_z) begin
      state_q     <= S_EMPTY;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_unexp_q <= err_unexp_d;
    end
  end

`ifdef QDR_ARB_RSP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_tmo_q, err_tmo_d;

  // Counter saturates at the limit; the error flag is sticky.
  always_comb begin : tmo
    tmo_cnt_d = tmo_cnt_q;
    err_tmo_d = err_tmo_q;
    if (i_mem_rvalid || (cnt_q == '0)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_W'(TIMEOUT)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
      err_tmo_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_z) begin
    if (!i_reset_z) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign o_err_timeout = err_tmo_q;
`endif

  assign o_req_grant = gnt;
  assign o_mem_valid = (state_q == S_FULL);
  assign o_mem_write = mem_write_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (state_q == S_FULL) || (cnt_q != '0);
  assign o_err_unexp = err_unexp_q;

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// tb_qdr_port_arbiter: scoreboard bench with a queue-based reference model.
// Directed scenarios followed by a randomized traffic phase.
`timescale 1ns/1ps
module tb_qdr_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 36;
  localparam int BW = 4;
  localparam int TD = 16;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } cmd_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    longint        due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v, req_w;
  logic [AW-1:0]   req_a [N];
  logic [DW-1:0]   req_d [N];
  logic [BW-1:0]   req_b [N];
  logic [N*AW-1:0] req_a_p;
  logic [N*DW-1:0] req_d_p;
  logic [N*BW-1:0] req_b_p;
  logic            mem_ready, mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic [N-1:0]    o_req_grant, o_rsp_valid;
  logic            o_mem_valid, o_mem_write, o_busy, o_err_unexp;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata, o_rsp_data;
  logic [BW-1:0]   o_mem_be;
`ifdef QDR_ARB_RSP_TIMEOUT_EN
  logic            o_err_timeout;
`endif

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_a_p[k*AW +: AW] = req_a[k];
      req_d_p[k*DW +: DW] = req_d[k];
      req_b_p[k*BW +: BW] = req_b[k];
    end
  end

  qdr_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
    .TAG_DEPTH(TD), .TIMEOUT(1024)
  ) dut (
    .i_clk(clk),
    .i_reset_z(rst_n),
    .i_req_valid(req_v),
    .i_req_write(req_w),
    .i_req_addr(req_a_p),
    .i_req_wdata(req_d_p),
    .i_req_be(req_b_p),
    .o_req_grant(o_req_grant),
    .o_mem_valid(o_mem_valid),
    .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be),
    .i_mem_ready(mem_ready),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data),
    .o_busy(o_busy),
    .o_err_unexp(o_err_unexp)
`ifdef QDR_ARB_RSP_TIMEOUT_EN
    ,
    .o_err_timeout(o_err_timeout)
`endif
  );

  // Reference model state
  cmd_t   cmd_q [$];
  rsp_t   rsp_q [$];
  int     tag_q [$];
  int     m_ptr;
  bit     m_full;
  bit     m_err;
  int     issued_reads;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     gcnt [N];
  int     keep_mode [N];
  logic [N-1:0] gseq [$];
  logic [N-1:0] gnt_seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    return DW'({$urandom, $urandom});
  endfunction

  task automatic model_reset();
    m_ptr = N - 1;
    m_full = 1'b0;
    m_err = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    tag_q.delete();
    issued_reads = 0;
  endtask

  // mode 1: write, 2: read, other: random type
  task automatic new_cmd(input int k, input int mode);
    req_v[k] = 1'b1;
    req_w[k] = (mode == 1) ? 1'b1 :
               (mode == 2) ? 1'b0 : 1'($urandom_range(1));
    req_a[k] = AW'($urandom);
    req_d[k] = rnd_d();
    req_b[k] = BW'($urandom);
  endtask

  task automatic ret(input logic [DW-1:0] d);
    mem_rvalid = 1'b1;
    mem_rdata = d;
    if (issued_reads > 0) issued_reads--;
  endtask

  // One clock: check grant and registered state, then advance the model.
  task automatic tick();
    int g;
    @(negedge clk);
    chk("mem_valid", o_mem_valid, m_full);
    chk("busy", o_busy, (m_full || tag_q.size() != 0));
    chk("err_unexp", o_err_unexp, m_err);
    g = -1;
    if (!m_full || mem_ready) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (g < 0 && req_v[k] && (req_w[k] || tag_q.size() < TD)) g = k;
      end
    end
    chk("grant", o_req_grant, (g < 0) ? 64'd0 : (64'd1 << g));
    gnt_seen = o_req_grant;
    if (o_req_grant != '0) gseq.push_back(o_req_grant);
    for (int k = 0; k < N; k++) if (o_req_grant[k]) gcnt[k]++;
    if (mem_rvalid) begin
      if (tag_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        rsp_t r;
        r.id = tag_q.pop_front();
        r.d = mem_rdata;
        r.due = cyc + 1;
        rsp_q.push_back(r);
      end
    end
    if (g >= 0) begin
      cmd_q.push_back({req_w[g], req_a[g], req_d[g], req_b[g]});
      if (!req_w[g]) tag_q.push_back(g);
      m_ptr = g;
      m_full = 1'b1;
    end else if (mem_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    if (g >= 0) begin
      if (keep_mode[g] != 0) new_cmd(g, keep_mode[g]);
      else req_v[g] = 1'b0;
    end
  endtask

  task automatic wait_grant(input int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt_seen != (N'(1) << k) && n < 20);
    chk("wait_grant", gnt_seen, 64'd1 << k);
  endtask

  task automatic drain();
    req_v = '0;
    mem_ready = 1'b1;
    for (int i = 0; i < 300 && (tag_q.size() > 0 || m_full); i++) begin
      if (issued_reads > 0) ret(rnd_d());
      tick();
    end
    tick();
    chk("drain_busy", o_busy, 0);
  endtask

  // Monitor: commands and responses checked against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_mem_valid) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_cmd: got command %0h with none expected",
                   o_mem_addr);
        end else begin
          chk("mem_cmd", {o_mem_write, o_mem_addr, o_mem_wdata, o_mem_be},
              cmd_q[0]);
          if (mem_ready) begin
            cmd_t c;
            c = cmd_q.pop_front();
            if (!c.w) issued_reads++;
          end
        end
      end
      if (o_rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexp: got %b expected none", o_rsp_valid);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_id", o_rsp_valid, 64'd1 << r.id);
          chk("rsp_data", o_rsp_data, r.d);
          chk("rsp_lat", cyc, r.due);
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rsp_t r;
        r = rsp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing: got none expected id %0d data %0h",
                 r.id, r.d);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_valid"}, o_mem_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err_unexp, 0);
    chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
    chk({tag, "_rsp_data"}, o_rsp_data, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
  endtask

  task automatic order_phase(input string tag);
    gseq.delete();
    for (int k = 0; k < N; k++) begin
      keep_mode[k] = 0;
      new_cmd(k, 1);
      req_a[k] = AW'(32'h100 + k);
    end
    mem_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < N; i++)
      chk(tag, (i < gseq.size()) ? 64'(gseq[i]) : 64'd0, 64'd1 << i);
  endtask

  initial begin
    int n;
    req_v = '0;
    req_w = '0;
    for (int k = 0; k < N; k++) begin
      req_a[k] = '0;
      req_d[k] = '0;
      req_b[k] = '0;
      gcnt[k] = 0;
      keep_mode[k] = 0;
    end
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    gnt_seen = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    chk("reset_grant", o_req_grant, 0);
    rst_n = 1'b1;

    // Four writes granted 0,1,2,3
    order_phase("p1_order");

    // All requesters hold valid for 12 cycles
    for (int k = 0; k < N; k++) begin
      gcnt[k] = 0;
      keep_mode[k] = 1;
      new_cmd(k, 1);
    end
    repeat (12) tick();
    for (int k = 0; k < N; k++) keep_mode[k] = 0;
    req_v = '0;
    for (int k = 0; k < N; k++) chk("p2_fair", gcnt[k], 3);
    repeat (2) tick();

    // Controller stall freezes the command register
    for (int k = 0; k < N; k++) begin
      keep_mode[k] = 1;
      new_cmd(k, 1);
    end
    tick();
    mem_ready = 1'b0;
    gseq.delete();
    repeat (5) tick();
    chk("p3_stall_grants", gseq.size(), 0);
    mem_ready = 1'b1;
    repeat (4) tick();
    chk("p3_resume_grants", gseq.size(), 4);
    for (int k = 0; k < N; k++) keep_mode[k] = 0;
    drain();

    // Tag FIFO full blocks reads only
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    keep_mode[2] = 2;
    new_cmd(2, 2);
    n = 0;
    while (gcnt[2] < 16 && n < 40) begin
      tick();
      n++;
    end
    keep_mode[2] = 0;
    chk("p4_reads", gcnt[2], 16);
    new_cmd(1, 1);
    repeat (3) tick();
    chk("p4_write_pass", gcnt[1], 1);
    chk("p4_read_block", gcnt[2], 16);
    ret(rnd_d());
    tick();
    tick();
    chk("p4_read_resume", gcnt[2], 17);
    drain();

    // Interleaved reads routed back in order
    new_cmd(3, 2);
    wait_grant(3);
    new_cmd(1, 2);
    wait_grant(1);
    n = 0;
    while (issued_reads < 2 && n < 10) begin
      tick();
      n++;
    end
    chk("p5_issued", issued_reads, 2);
    ret(DW'(36'hA));
    tick();
    ret(DW'(36'hB));
    repeat (3) tick();
    chk("p5_drained", rsp_q.size(), 0);

    // Return with nothing in flight
    drain();
    mem_rvalid = 1'b1;
    mem_rdata = rnd_d();
    repeat (4) tick();
    chk("p6_err_sticky", o_err_unexp, 1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++)
        if (!req_v[k] && $urandom_range(9) < 4) new_cmd(k, 0);
      mem_ready = ($urandom_range(3) != 0);
      if (issued_reads > 0 && $urandom_range(2) == 0) ret(rnd_d());
      tick();
    end

    // Reset in the middle of traffic
    rst_n = 1'b0;
    req_v = '0;
    mem_rvalid = 1'b0;
    model_reset();
    #2;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    order_phase("rst_order");
    drain();

`ifdef QDR_ARB_RSP_TIMEOUT_EN
    chk("tmo_idle", o_err_timeout, 0);
    new_cmd(0, 2);
    wait_grant(0);
    repeat (1000) tick();
    chk("tmo_early", o_err_timeout, 0);
    repeat (40) tick();
    chk("tmo_set", o_err_timeout, 1);
    drain();
`endif

    chk("end_cmd_q", cmd_q.size(), 0);
    chk("end_rsp_q", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
